reg_to_apb: RTL

//  Register-bus responder bridging onto an APB4 requester port, so reg-bus masters reach APB peripherals.

---
 rtl/reg_to_apb_pkg.sv | 13 +
 rtl/reg_to_apb.sv | 117 +++++++++++
 2 files changed

// File: rtl/reg_to_apb_pkg.sv
// rtl/reg_to_apb_pkg.sv - shared types and constants for the reg-bus to APB bridge
package reg_to_apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  localparam logic [2:0] PPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/reg_to_apb.sv
// rtl/reg_to_apb.sv - reg-bus responder driving one APB4 transfer per request
module reg_to_apb
  import reg_to_apb_pkg::*;
#(
  parameter int unsigned AddrWidth     = 32,
  parameter int unsigned DataWidth     = 32,
  parameter int unsigned TimeoutCycles = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [AddrWidth-1:0]   reg_addr_i,
  input  logic                   reg_write_i,
  input  logic [DataWidth-1:0]   reg_wdata_i,
  input  logic [DataWidth/8-1:0] reg_wstrb_i,
  input  logic                   reg_valid_i,
  output logic [DataWidth-1:0]   reg_rdata_o,
  output logic                   reg_error_o,
  output logic                   reg_ready_o,
  output logic [AddrWidth-1:0]   paddr_o,
  output logic [2:0]             pprot_o,
  output logic                   psel_o,
  output logic                   penable_o,
  output logic                   pwrite_o,
  output logic [DataWidth-1:0]   pwdata_o,
  output logic [DataWidth/8-1:0] pstrb_o,
  input  logic                   pready_i,
  input  logic [DataWidth-1:0]   prdata_i,
  input  logic                   pslverr_i
);

  localparam int unsigned CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntWidth-1:0] CntLast =
    CntWidth'((TimeoutCycles > 0) ? (TimeoutCycles - 1) : 0);

  state_e              state_q;
  logic [CntWidth-1:0] cnt_q;
  logic                timeout_hit;

  assign pprot_o = PPROT_DEFAULT;

  always_comb begin
    timeout_hit = 1'b0;
    if (TimeoutCycles > 0) timeout_hit = (cnt_q == CntLast);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      paddr_o     <= '0;
      pwrite_o    <= 1'b0;
      pwdata_o    <= '0;
      pstrb_o     <= '0;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      reg_rdata_o <= '0;
      reg_error_o <= 1'b0;
      reg_ready_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (reg_valid_i) begin
            paddr_o  <= reg_addr_i;
            pwrite_o <= reg_write_i;
            pwdata_o <= reg_wdata_i;
            pstrb_o  <= reg_write_i ? reg_wstrb_i : '0;
            psel_o   <= 1'b1;
            cnt_q    <= '0;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          // pready in the final allowed cycle still counts as a normal completion
          if (pready_i) begin
            reg_error_o <= pslverr_i;
            reg_rdata_o <= pwrite_o ? '0 : prdata_i;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            reg_ready_o <= 1'b1;
            state_q     <= RESP;
          end else if (timeout_hit) begin
            reg_error_o <= 1'b1;
            reg_rdata_o <= '0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            reg_ready_o <= 1'b1;
            state_q     <= RESP;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP: begin
          reg_ready_o <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  a_psel_rise_in_setup: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $rose(psel_o) |-> (state_q == SETUP));
  a_penable_with_psel: assert property (@(posedge clk_i) disable iff (!rst_ni)
    penable_o |-> psel_o);
  a_apb_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (psel_o && $past(psel_o)) |-> ($stable(paddr_o) && $stable(pwrite_o) &&
                                   $stable(pwdata_o) && $stable(pstrb_o)));
  a_ready_single: assert property (@(posedge clk_i) disable iff (!rst_ni)
    reg_ready_o |=> !reg_ready_o);
  a_valid_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ((state_q == SETUP) || (state_q == ACCESS)) |-> reg_valid_i);

endmodule
